fetch_pc_unit: RTL and testbench
================================

# fetch_pc_unit

Program-counter and fetch-sequencing stage that sits directly upstream of the ALU in the single-cycle datapath. It holds the PC, drives the instruction-memory address, and applies redirects from the ALU's branch outputs (taken flag plus resolved label address). It also runs the program start/done handshake with the testbench or top level and keeps cycle and instruction counters for performance reporting.

## Interface
- CNT_W, 16, width of the cycle and instruction counters
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start_i  in  1  one-cycle pulse; begin execution at start_addr_i
- start_addr_i  in  8  program entry address, sampled only when start_i=1
- stall_i  in  1  hold the current PC this cycle (e.g. multi-cycle memory op)
- branch_taken_i  in  1  ALU branch-taken flag for the instruction at pc_o
- branch_target_i  in  8  ALU result used as the branch target when taken
- halt_i  in  1  decoder flag: the instruction at pc_o is the halt instruction
- pc_o  out  8  instruction-memory address (registered PC)
- fetch_valid_o  out  1  1 while state=RUN; downstream commits only when 1 and stall_i=0
- busy_o  out  1  1 in RUN
- done_o  out  1  1 in DONE; level, held until the next start_i
- start_addr_o  out  8  latched entry address (program selector for the label lookup)
- cycle_cnt_o  out  CNT_W  cycles spent in RUN, including stall cycles
- instr_cnt_o  out  CNT_W  instructions retired (RUN, stall_i=0)

## Operation
- States: IDLE, RUN, DONE.
  - IDLE: start_i -> RUN.
  - RUN: halt_i=1 and stall_i=0 -> DONE; start_i -> RUN (restart).
  - DONE: start_i -> RUN.
- start_i in any state, including mid-RUN:
  - pc <= start_addr_i; start_addr_o <= start_addr_i.
  - Both counters clear to 0. done_o falls.
  - start_i has priority over halt, branch and stall in the same cycle.
- Next PC in RUN, highest priority first:
  - start_i
  - stall_i=1: PC held
  - halt_i=1: PC held; go to DONE
  - branch_taken_i=1: PC <= branch_target_i
  - otherwise: PC <= PC+1
- PC arithmetic is 8-bit modulo: 0xFF+1 = 0x00, with no flag and no stop.
- Branch_target_i equal to the current PC is legal (self-loop); the PC reloads the same value.
- Branch_taken_i and branch_target_i are ignored outside RUN and when stall_i=1.
- Counters:
  - cycle_cnt increments every RUN cycle.
  - instr_cnt increments on RUN cycles with stall_i=0, including the halt cycle.
  - Both saturate at all-ones and never wrap.
- In IDLE and DONE, pc_o, start_addr_o and both counters hold their values.

## Timing
- Reset values: state=IDLE, pc_o=0x00, start_addr_o=0x00, counters=0, fetch_valid_o=0, busy_o=0, done_o=0.
- Reset asserted mid-RUN returns everything to the reset values asynchronously. After release, the block waits in IDLE for start_i.
- Every output is registered or a decode of registered state; there is no combinational input-to-output path.
- Start latency:
  - start_i sampled at edge N.
  - From edge N: pc_o=start_addr_i, fetch_valid_o=1.
  - First instruction executes in cycle N..N+1.
- Fetch and execute are single-cycle. The branch decision from the instruction at pc_o takes effect at the next edge, so there are zero delay slots and nothing to flush.
- Halt:
  - Halt instruction executes in cycle K.
  - After edge K+1: done_o=1, fetch_valid_o=0, pc_o still holds the halt address.
- Stall: each cycle with stall_i=1 in RUN adds exactly one cycle of latency. The PC and instr_cnt are unchanged.

## Test plan
- Reset, then start_i with start_addr_i=0x40, 5 sequential non-branch instructions, then halt at 0x45 -> pc_o 0x40..0x45, done_o=1 one edge after the halt cycle, instr_cnt=6, cycle_cnt=6.
- Running at pc=0x4C, branch_taken_i=1 with branch_target_i=0x4A -> next pc_o=0x4A. The same stimulus with branch_taken_i=0 -> pc_o=0x4D.
- Start at 0xFE with no branches -> pc_o sequence 0xFE, 0xFF, 0x00, 0x01; busy_o stays 1.
- stall_i=1 for 3 cycles at pc=0x10, with branch_taken_i=1 during the stall -> pc_o stays 0x10, cycle_cnt +3, instr_cnt +0. The branch is ignored.
- Same-cycle conflicts:
  - halt_i=1 and branch_taken_i=1 together -> DONE, pc_o unchanged.
  - start_i=1 (addr 0x00) mid-RUN at pc=0x55 -> pc_o=0x00, counters 0, done_o=0.
- reset pulse mid-RUN at pc=0x37 with counters nonzero -> all outputs return to their reset values immediately. After release the block stays IDLE until start_i.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
//
// Program-counter and fetch-sequencing stage feeding the single-cycle datapath.
// It holds the PC, applies ALU branch redirects, runs the start/done handshake
// and keeps saturating cycle and instruction counters.
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous active-high reset
//   start_i          one-cycle pulse: (re)start execution at start_addr_i
//   start_addr_i     program entry address, sampled when start_i=1
//   stall_i          hold the PC this cycle
//   branch_taken_i   branch-taken flag for the instruction at pc_o
//   branch_target_i  branch target used when taken
//   halt_i           instruction at pc_o is the halt instruction
//   pc_o             registered PC / instruction-memory address
//   fetch_valid_o    1 while running
//   busy_o           1 while running
//   done_o           1 after halt, held until the next start_i
//   start_addr_o     latched entry address
//   cycle_cnt_o      cycles spent running, stalls included (saturating)
//   instr_cnt_o      instructions retired (saturating)
module fetch_pc_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [7:0]       start_addr_i,
  input  logic             stall_i,
  input  logic             branch_taken_i,
  input  logic [7:0]       branch_target_i,
  input  logic             halt_i,
  output logic [7:0]       pc_o,
  output logic             fetch_valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [7:0]       start_addr_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           r_state;
  logic [7:0]       r_pc;
  logic [7:0]       r_start_addr;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instr_cnt;

  // An instruction retires on every running cycle that is not stalled,
  // including the halt instruction itself.
  logic w_retire;
  assign w_retire = (r_state == StRun) && !stall_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= StIdle;
      r_pc         <= 8'h00;
      r_start_addr <= 8'h00;
      r_cycle_cnt  <= '0;
      r_instr_cnt  <= '0;
    end else if (start_i) begin
      // Start wins over stall, halt and branch, in every state.
      r_state      <= StRun;
      r_pc         <= start_addr_i;
      r_start_addr <= start_addr_i;
      r_cycle_cnt  <= '0;
      r_instr_cnt  <= '0;
    end else if (r_state == StRun) begin
      if (r_cycle_cnt != CntMax) begin
        r_cycle_cnt <= r_cycle_cnt + CntOne;
      end
      if (w_retire) begin
        if (r_instr_cnt != CntMax) begin
          r_instr_cnt <= r_instr_cnt + CntOne;
        end
        if (halt_i) begin
          // PC keeps pointing at the halt instruction.
          r_state <= StDone;
        end else if (branch_taken_i) begin
          r_pc <= branch_target_i;
        end else begin
          r_pc <= r_pc + 8'd1; // wraps 0xFF -> 0x00
        end
      end
    end
  end

  assign pc_o          = r_pc;
  assign start_addr_o  = r_start_addr;
  assign cycle_cnt_o   = r_cycle_cnt;
  assign instr_cnt_o   = r_instr_cnt;
  assign fetch_valid_o = (r_state == StRun);
  assign busy_o        = (r_state == StRun);
  assign done_o        = (r_state == StDone);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: the driver applies stimulus, advances a
// behavioural model one clock and queues the expected outputs; an independent
// monitor pops each entry shortly afterwards and compares it with the DUT.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [7:0]  start_addr_i;
  logic        stall_i;
  logic        branch_taken_i;
  logic [7:0]  branch_target_i;
  logic        halt_i;
  logic [7:0]  pc_o;
  logic        fetch_valid_o;
  logic        busy_o;
  logic        done_o;
  logic [7:0]  start_addr_o;
  logic [15:0] cycle_cnt_o;
  logic [15:0] instr_cnt_o;

  fetch_pc_unit #(.CNT_W(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .start_i         (start_i),
    .start_addr_i    (start_addr_i),
    .stall_i         (stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .halt_i          (halt_i),
    .pc_o            (pc_o),
    .fetch_valid_o   (fetch_valid_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .start_addr_o    (start_addr_o),
    .cycle_cnt_o     (cycle_cnt_o),
    .instr_cnt_o     (instr_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pc;
    int sa;
    int cyc;
    int ins;
    int mode; // 0 idle, 1 running, 2 done
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: program state in plain integers.
  int m_mode, m_pc, m_sa, m_cyc, m_ins;
  localparam int CntLimit = 65535;

  function automatic int sat_inc(input int v);
    return (v >= CntLimit) ? CntLimit : v + 1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_sa = 0; m_cyc = 0; m_ins = 0;
  endtask

  // One clock edge of the program sequencer as seen from the outside.
  task automatic model_clock();
    if (start_i) begin
      m_mode = 1; m_pc = int'(start_addr_i); m_sa = m_pc; m_cyc = 0; m_ins = 0;
    end else if (m_mode == 1) begin
      m_cyc = sat_inc(m_cyc);
      if (!stall_i) begin
        m_ins = sat_inc(m_ins);
        if (halt_i)              m_mode = 2;
        else if (branch_taken_i) m_pc = int'(branch_target_i);
        else                     m_pc = (m_pc + 1) % 256;
      end
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.pc = m_pc; e.sa = m_sa; e.cyc = m_cyc; e.ins = m_ins; e.mode = m_mode;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (reset) model_reset();
    else       model_clock();
    push_exp();
  endtask

  task automatic step(input logic s, input logic [7:0] a, input logic st,
                      input logic br, input logic [7:0] tg, input logic h);
    start_i = s; start_addr_i = a; stall_i = st;
    branch_taken_i = br; branch_target_i = tg; halt_i = h;
    tick();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic chk(input string nm, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Monitor: every queued expectation is checked 2 time units after it appears.
  initial begin
    exp_t e;
    forever begin
      wait (exp_q.size() != 0);
      #2;
      e = exp_q.pop_front();
      chk("pc_o", int'(pc_o), e.pc);
      chk("start_addr_o", int'(start_addr_o), e.sa);
      chk("cycle_cnt_o", int'(cycle_cnt_o), e.cyc);
      chk("instr_cnt_o", int'(instr_cnt_o), e.ins);
      chk("fetch_valid_o", int'(fetch_valid_o), (e.mode == 1) ? 1 : 0);
      chk("busy_o", int'(busy_o), (e.mode == 1) ? 1 : 0);
      chk("done_o", int'(done_o), (e.mode == 2) ? 1 : 0);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    start_i = 1'b0; start_addr_i = 8'h00; stall_i = 1'b0;
    branch_taken_i = 1'b0; branch_target_i = 8'h00; halt_i = 1'b0;
    model_reset();
    tick();
    tick();
    reset = 1'b0;
    run(2); // stays idle without start

    // Straight-line program 0x40..0x45 ending in halt, then done held.
    step(1'b1, 8'h40, 1'b0, 1'b0, 8'h00, 1'b0);
    run(5);
    step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    run(3);

    // Taken and not-taken branch from 0x4C.
    step(1'b1, 8'h4C, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'h4A, 1'b0);
    step(1'b1, 8'h4C, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 8'h4A, 1'b0);
    // Self-loop branch.
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'h4D, 1'b0);

    // PC wrap.
    step(1'b1, 8'hFE, 1'b0, 1'b0, 8'h00, 1'b0);
    run(4);

    // Stall with a branch presented during the stall.
    step(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b1, 8'h99, 1'b0);
    run(2);

    // Halt and branch together; stalled halt is ignored first.
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'h77, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 1'b0); // branch ignored in DONE

    // Restart mid-run at 0x55 with competing halt/branch.
    step(1'b1, 8'h50, 1'b0, 1'b0, 8'h00, 1'b0);
    run(5);
    step(1'b1, 8'h00, 1'b1, 1'b1, 8'h33, 1'b1);
    run(2);

    // Asynchronous reset mid-run at 0x37.
    step(1'b1, 8'h30, 1'b0, 1'b0, 8'h00, 1'b0);
    run(7);
    @(negedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    push_exp();
    tick();
    reset = 1'b0;
    run(3);

    // Counter saturation: long run without stalls, then with stalls.
    step(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 65540; i++)
      step(1'b0, 8'h00, 1'b0, ($urandom_range(0, 7) == 0), 8'($urandom), 1'b0);
    for (int i = 0; i < 20; i++)
      step(1'b0, 8'h00, ($urandom_range(0, 1) == 0), 1'b0, 8'h00, 1'b0);

    // Random mix.
    for (int i = 0; i < 1500; i++)
      step(($urandom_range(0, 39) == 0), 8'($urandom), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0), 8'($urandom), ($urandom_range(0, 19) == 0));

    #5;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
